// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes, NOP encoding, decode-stage state and source-use decode
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_R      = 7'b0110011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} id_state_e;

   // Unknown opcodes are treated as reading rs1 so a hazard is never missed.
   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use compare between the instruction in ID and the load in EX
module hazard_detect
   import riscv_pkg::*;
(
   input  logic       id_valid,
   input  logic [6:0] opcode,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rd,
   output logic       load_use
);

   logic hit_rs1;
   logic hit_rs2;

   always_comb begin
      hit_rs1  = uses_rs1(opcode) && (rs1 == idex_rd);
      hit_rs2  = uses_rs2(opcode) && (rs2 == idex_rd);
      // x0 is never really written, so a load to x0 cannot create a hazard.
      load_use = id_valid && idex_mem_read && (idex_rd != 5'd0) && (hit_rs1 || hit_rs2);
   end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// rtl/if_id_hazard_ctrl.sv - IF/ID register with load-use stall and redirect flush sequencing
module if_id_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 2,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_pc,
   input  logic [31:0]      fetch_inst,
   output logic             fetch_ready,
   output logic             pc_write_en,
   input  logic             ex_ready,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rd,
   input  logic             redirect_valid,
   output logic             id_valid,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? CW'(LOAD_STALL_CYCLES - 2) : '0;

   id_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_use;
   logic          load_ifid;
   logic          squash;
   logic          inc_stall;
   logic          inc_flush;

   hazard_detect u_hazard_detect (
      .id_valid      (id_valid),
      .opcode        (id_inst[6:0]),
      .rs1           (id_inst[19:15]),
      .rs2           (id_inst[24:20]),
      .idex_mem_read (idex_mem_read),
      .idex_rd       (idex_rd),
      .load_use      (load_use)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fetch_ready = 1'b0;
      pc_write_en = 1'b0;
      idex_bubble = 1'b0;
      load_ifid   = 1'b0;
      squash      = 1'b0;
      inc_stall   = 1'b0;
      inc_flush   = 1'b0;
      // A redirect outranks everything, including a pending load-use bubble.
      if (redirect_valid) begin
         fetch_ready = 1'b1;
         pc_write_en = 1'b1;
         squash      = 1'b1;
         inc_flush   = 1'b1;
         cnt_d       = FLUSH_RELOAD;
         state_d     = FLUSH;
      end else begin
         case (state_q)
            RUN: begin
               if (!ex_ready) begin
                  state_d = RUN;
               end else if (load_use) begin
                  idex_bubble = 1'b1;
                  inc_stall   = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     cnt_d   = STALL_RELOAD;
                     state_d = STALL;
                  end
               end else begin
                  fetch_ready = 1'b1;
                  pc_write_en = 1'b1;
                  load_ifid   = 1'b1;
               end
            end
            STALL: begin
               if (ex_ready) begin
                  idex_bubble = 1'b1;
                  inc_stall   = 1'b1;
                  if (cnt_q == '0) state_d = RUN;
                  else             cnt_d   = cnt_q - 1'b1;
               end
            end
            FLUSH: begin
               // Cycle-counted: wrong-path beats drain even while EX holds.
               fetch_ready = 1'b1;
               pc_write_en = 1'b1;
               squash      = 1'b1;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_inst     <= NOP_INST;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (squash) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
         end else if (load_ifid) begin
            id_valid <= fetch_valid;
            id_pc    <= fetch_pc;
            id_inst  <= fetch_inst;
         end
         if (inc_stall) stall_count <= stall_count + CNT_W'(1);
         if (inc_flush) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb/tb_if_id_hazard_ctrl.sv - directed bench for if_id_hazard_ctrl (single- and triple-bubble builds)
module tb_if_id_hazard_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ADD = 32'h0020_8133;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        ex_ready;
   logic        idex_mem_read;
   logic [4:0]  idex_rd;
   logic        redirect_valid;

   logic        a_fetch_ready, a_pc_write_en, a_id_valid, a_idex_bubble;
   logic [31:0] a_id_pc, a_id_inst;
   logic [15:0] a_stall_count, a_flush_count;
   logic        b_fetch_ready, b_pc_write_en, b_id_valid, b_idex_bubble;
   logic [31:0] b_id_pc, b_id_inst;
   logic [15:0] b_stall_count, b_flush_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .fetch_ready(a_fetch_ready), .pc_write_en(a_pc_write_en), .ex_ready(ex_ready),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .redirect_valid(redirect_valid),
      .id_valid(a_id_valid), .id_pc(a_id_pc), .id_inst(a_id_inst), .idex_bubble(a_idex_bubble),
      .stall_count(a_stall_count), .flush_count(a_flush_count));

   if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .fetch_ready(b_fetch_ready), .pc_write_en(b_pc_write_en), .ex_ready(ex_ready),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .redirect_valid(redirect_valid),
      .id_valid(b_id_valid), .id_pc(b_id_pc), .id_inst(b_id_inst), .idex_bubble(b_idex_bubble),
      .stall_count(b_stall_count), .flush_count(b_flush_count));

   // Inputs change just after the falling edge; outputs are sampled #1 later.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_inst = '0; ex_ready = 1'b1;
      idex_mem_read = 1'b0; idex_rd = '0; redirect_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (a_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid: got %0b exp 0", a_id_valid); end
      n_chk++; if (a_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_id_pc: got %h exp 0", a_id_pc); end
      n_chk++; if (a_id_inst !== NOP) begin n_err++; $display("FAIL rst_id_inst: got %h exp %h", a_id_inst, NOP); end
      n_chk++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL rst_stall_count: got %0d exp 0", a_stall_count); end
      n_chk++; if (a_flush_count !== 16'd0) begin n_err++; $display("FAIL rst_flush_count: got %0d exp 0", a_flush_count); end
      n_chk++; if (a_fetch_ready !== 1'b1) begin n_err++; $display("FAIL rst_fetch_ready: got %0b exp 1", a_fetch_ready); end
      n_chk++; if (b_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_id_valid: got %0b exp 0", b_id_valid); end
   endtask

   task automatic test_fetch();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h0; fetch_inst = 32'h0050_0093;
      #1;
      n_chk++; if (a_pc_write_en !== 1'b1) begin n_err++; $display("FAIL fetch_pc_we: got %0b exp 1", a_pc_write_en); end
      tick(); #1;
      n_chk++; if (a_id_valid !== 1'b1) begin n_err++; $display("FAIL fetch_id_valid: got %0b exp 1", a_id_valid); end
      n_chk++; if (a_id_inst !== 32'h0050_0093) begin n_err++; $display("FAIL fetch_id_inst: got %h exp 00500093", a_id_inst); end
      n_chk++; if (a_id_pc !== 32'h0) begin n_err++; $display("FAIL fetch_id_pc: got %h exp 0", a_id_pc); end
   endtask

   task automatic test_load_use();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h4; fetch_inst = ADD;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd1; fetch_pc = 32'h8; fetch_inst = 32'h0040_0113;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %0b exp 1", a_idex_bubble); end
      n_chk++; if (a_pc_write_en !== 1'b0) begin n_err++; $display("FAIL lu_pc_we: got %0b exp 0", a_pc_write_en); end
      n_chk++; if (a_fetch_ready !== 1'b0) begin n_err++; $display("FAIL lu_fetch_ready: got %0b exp 0", a_fetch_ready); end
      tick(); #1;
      n_chk++; if (a_stall_count !== 16'd1) begin n_err++; $display("FAIL lu_stall_count: got %0d exp 1", a_stall_count); end
      n_chk++; if (a_id_inst !== ADD) begin n_err++; $display("FAIL lu_held_inst: got %h exp %h", a_id_inst, ADD); end
      n_chk++; if (a_id_pc !== 32'h4) begin n_err++; $display("FAIL lu_held_pc: got %h exp 4", a_id_pc); end
      idex_mem_read = 1'b0;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL lu_release_bubble: got %0b exp 0", a_idex_bubble); end
      tick(); #1;
      n_chk++; if (a_id_pc !== 32'h8) begin n_err++; $display("FAIL lu_advance_pc: got %h exp 8", a_id_pc); end
   endtask

   task automatic test_stall3();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h4; fetch_inst = ADD;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd2; fetch_pc = 32'h8; fetch_inst = 32'h0040_0113;
      #1;
      n_chk++; if (b_idex_bubble !== 1'b1) begin n_err++; $display("FAIL s3_bubble1: got %0b exp 1", b_idex_bubble); end
      tick();
      idex_mem_read = 1'b0;
      #1;
      n_chk++; if (b_idex_bubble !== 1'b1) begin n_err++; $display("FAIL s3_bubble2: got %0b exp 1", b_idex_bubble); end
      n_chk++; if (b_pc_write_en !== 1'b0) begin n_err++; $display("FAIL s3_pc_we2: got %0b exp 0", b_pc_write_en); end
      tick(); #1;
      n_chk++; if (b_idex_bubble !== 1'b1) begin n_err++; $display("FAIL s3_bubble3: got %0b exp 1", b_idex_bubble); end
      tick(); #1;
      n_chk++; if (b_idex_bubble !== 1'b0) begin n_err++; $display("FAIL s3_no_bubble4: got %0b exp 0", b_idex_bubble); end
      n_chk++; if (b_stall_count !== 16'd3) begin n_err++; $display("FAIL s3_stall_count: got %0d exp 3", b_stall_count); end
      n_chk++; if (b_id_inst !== ADD) begin n_err++; $display("FAIL s3_held_inst: got %h exp %h", b_id_inst, ADD); end
      tick(); #1;
      n_chk++; if (b_id_pc !== 32'h8) begin n_err++; $display("FAIL s3_advance_pc: got %h exp 8", b_id_pc); end
   endtask

   task automatic test_redirect_in_stall();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h10; fetch_inst = ADD;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd1;
      tick();
      idex_mem_read = 1'b0;
      tick();
      redirect_valid = 1'b1;
      #1;
      n_chk++; if (b_idex_bubble !== 1'b0) begin n_err++; $display("FAIL rs_bubble: got %0b exp 0", b_idex_bubble); end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_chk++; if (b_stall_count !== 16'd2) begin n_err++; $display("FAIL rs_stall_count: got %0d exp 2", b_stall_count); end
      n_chk++; if (b_flush_count !== 16'd1) begin n_err++; $display("FAIL rs_flush_count: got %0d exp 1", b_flush_count); end
      n_chk++; if (b_id_valid !== 1'b0) begin n_err++; $display("FAIL rs_id_valid: got %0b exp 0", b_id_valid); end
   endtask

   task automatic test_redirect_vs_load_use();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h4; fetch_inst = ADD;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd1; redirect_valid = 1'b1;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL rl_bubble: got %0b exp 0", a_idex_bubble); end
      tick();
      redirect_valid = 1'b0; idex_mem_read = 1'b0;
      #1;
      n_chk++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL rl_stall_count: got %0d exp 0", a_stall_count); end
      n_chk++; if (a_flush_count !== 16'd1) begin n_err++; $display("FAIL rl_flush_count: got %0d exp 1", a_flush_count); end
      n_chk++; if (a_id_inst !== NOP) begin n_err++; $display("FAIL rl_id_inst: got %h exp %h", a_id_inst, NOP); end
   endtask

   task automatic test_flush();
      do_reset();
      redirect_valid = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h40; fetch_inst = 32'h0010_0093;
      tick();
      redirect_valid = 1'b0; ex_ready = 1'b0; fetch_pc = 32'h80; fetch_inst = 32'h00A0_0093;
      #1;
      n_chk++; if (a_flush_count !== 16'd1) begin n_err++; $display("FAIL fl_flush_count: got %0d exp 1", a_flush_count); end
      n_chk++; if (a_fetch_ready !== 1'b1) begin n_err++; $display("FAIL fl_fetch_ready: got %0b exp 1", a_fetch_ready); end
      tick();
      fetch_pc = 32'h84; fetch_inst = 32'h0020_0113;
      #1;
      n_chk++; if (a_id_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop1: got %0b exp 0", a_id_valid); end
      tick();
      ex_ready = 1'b1; fetch_pc = 32'h88; fetch_inst = 32'h0030_0193;
      #1;
      n_chk++; if (a_id_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop2: got %0b exp 0", a_id_valid); end
      tick(); #1;
      n_chk++; if (a_id_valid !== 1'b1) begin n_err++; $display("FAIL fl_third_valid: got %0b exp 1", a_id_valid); end
      n_chk++; if (a_id_inst !== 32'h0030_0193) begin n_err++; $display("FAIL fl_third_inst: got %h exp 00300193", a_id_inst); end
      n_chk++; if (a_id_pc !== 32'h88) begin n_err++; $display("FAIL fl_third_pc: got %h exp 88", a_id_pc); end
   endtask

   task automatic test_no_hazard();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h0; fetch_inst = 32'h0000_0133;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd0;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL nh_rd0_bubble: got %0b exp 0", a_idex_bubble); end
      n_chk++; if (a_fetch_ready !== 1'b1) begin n_err++; $display("FAIL nh_rd0_ready: got %0b exp 1", a_fetch_ready); end
      idex_mem_read = 1'b0; fetch_pc = 32'h4; fetch_inst = 32'h1234_50B7;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd1;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL nh_lui_rd1: got %0b exp 0", a_idex_bubble); end
      idex_rd = 5'd8;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL nh_lui_rs1field: got %0b exp 0", a_idex_bubble); end
      idex_rd = 5'd3;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL nh_lui_rs2field: got %0b exp 0", a_idex_bubble); end
      idex_mem_read = 1'b0; fetch_pc = 32'h8; fetch_inst = 32'h0050_8093;
      tick();
      idex_mem_read = 1'b1; idex_rd = 5'd5;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL nh_imm_rs2field: got %0b exp 0", a_idex_bubble); end
      idex_rd = 5'd1;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b1) begin n_err++; $display("FAIL nh_imm_rs1_hit: got %0b exp 1", a_idex_bubble); end
      idex_mem_read = 1'b0;
   endtask

   task automatic test_hold();
      do_reset();
      fetch_valid = 1'b1; fetch_pc = 32'h20; fetch_inst = ADD;
      tick();
      ex_ready = 1'b0; idex_mem_read = 1'b1; idex_rd = 5'd1; fetch_pc = 32'h24; fetch_inst = 32'h0040_0113;
      #1;
      n_chk++; if (a_idex_bubble !== 1'b0) begin n_err++; $display("FAIL hd_run_bubble: got %0b exp 0", a_idex_bubble); end
      n_chk++; if (a_pc_write_en !== 1'b0) begin n_err++; $display("FAIL hd_run_pc_we: got %0b exp 0", a_pc_write_en); end
      n_chk++; if (a_fetch_ready !== 1'b0) begin n_err++; $display("FAIL hd_run_ready: got %0b exp 0", a_fetch_ready); end
      tick(); tick(); #1;
      n_chk++; if (a_stall_count !== 16'd0) begin n_err++; $display("FAIL hd_run_stall_count: got %0d exp 0", a_stall_count); end
      n_chk++; if (a_id_pc !== 32'h20) begin n_err++; $display("FAIL hd_run_id_pc: got %h exp 20", a_id_pc); end
      ex_ready = 1'b1;
      #1;
      n_chk++; if (b_idex_bubble !== 1'b1) begin n_err++; $display("FAIL hd_b_bubble1: got %0b exp 1", b_idex_bubble); end
      tick();
      ex_ready = 1'b0;
      #1;
      n_chk++; if (b_idex_bubble !== 1'b0) begin n_err++; $display("FAIL hd_stall_bubble: got %0b exp 0", b_idex_bubble); end
      n_chk++; if (b_pc_write_en !== 1'b0) begin n_err++; $display("FAIL hd_stall_pc_we: got %0b exp 0", b_pc_write_en); end
      tick(); tick(); #1;
      n_chk++; if (b_stall_count !== 16'd1) begin n_err++; $display("FAIL hd_stall_count_frozen: got %0d exp 1", b_stall_count); end
      n_chk++; if (b_id_inst !== ADD) begin n_err++; $display("FAIL hd_stall_id_inst: got %h exp %h", b_id_inst, ADD); end
      ex_ready = 1'b1; idex_mem_read = 1'b0;
      tick(); tick(); #1;
      n_chk++; if (b_stall_count !== 16'd3) begin n_err++; $display("FAIL hd_stall_resume: got %0d exp 3", b_stall_count); end
      n_chk++; if (b_idex_bubble !== 1'b0) begin n_err++; $display("FAIL hd_stall_done: got %0b exp 0", b_idex_bubble); end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h30; fetch_inst = 32'h0050_0093;
      #1;
      n_chk++; if (a_id_inst !== NOP) begin n_err++; $display("FAIL rf_id_inst: got %h exp %h", a_id_inst, NOP); end
      n_chk++; if (a_flush_count !== 16'd0) begin n_err++; $display("FAIL rf_flush_count: got %0d exp 0", a_flush_count); end
      n_chk++; if (a_id_valid !== 1'b0) begin n_err++; $display("FAIL rf_id_valid: got %0b exp 0", a_id_valid); end
      tick(); #1;
      n_chk++; if (a_id_valid !== 1'b1) begin n_err++; $display("FAIL rf_run_accept: got %0b exp 1", a_id_valid); end
      n_chk++; if (a_id_pc !== 32'h30) begin n_err++; $display("FAIL rf_run_pc: got %h exp 30", a_id_pc); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fetch();
      test_load_use();
      test_stall3();
      test_redirect_in_stall();
      test_redirect_vs_load_use();
      test_flush();
      test_no_hazard();
      test_hold();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
